// File: rtl/bitcheck_arbiter.sv
// Round-robin arbiter sharing one bitcheck unit between two requesters.
// One transaction in flight: accept, hold operands CHECK_LAT cycles, return the tagged result.
module bitcheck_arbiter #(
  parameter int CHECK_LAT = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_date,
  input  logic             req0_fun,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_date,
  input  logic             req1_fun,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic [31:0]      ck_date,
  output logic             ck_fun,
  input  logic [31:0]      ck_result,
  output logic [CNT_W-1:0] serve_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT = 4'(CHECK_LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_id;
  logic             r_rsp_id;
  logic [3:0]       r_wait_cnt;
  logic [31:0]      r_ck_date;
  logic             r_ck_fun;
  logic [31:0]      r_rsp_result;
  logic [CNT_W-1:0] r_serve_cnt;

  logic w_grant;
  logic w_accept;
  logic w_last;
  logic w_handshake;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    w_grant     = req1_valid;
    w_accept    = (r_state == S_IDLE) && !reset && (req0_valid || req1_valid);
    w_last      = (r_state == S_WAIT) && (r_wait_cnt == 4'd1);
    w_handshake = (r_state == S_RESP) && rsp_ready;
    w_state_nxt = r_state;
    if (req0_valid && req1_valid) w_grant = r_prio;
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_nxt = S_WAIT;
      S_WAIT:  if (w_last)      w_state_nxt = S_RESP;
      S_RESP:  if (w_handshake) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is withheld during reset so nothing is accepted on a reset edge.
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept &&  w_grant;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign ck_date    = r_ck_date;
  assign ck_fun     = r_ck_fun;
  assign serve_cnt  = r_serve_cnt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Every datapath register is reset; an in-flight transaction is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio       <= 1'b0;
      r_id         <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_wait_cnt   <= 4'd0;
      r_ck_date    <= 32'd0;
      r_ck_fun     <= 1'b0;
      r_rsp_result <= 32'd0;
      r_serve_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_ck_date  <= w_grant ? req1_date : req0_date;
        r_ck_fun   <= w_grant ? req1_fun  : req0_fun;
        r_id       <= w_grant;
        r_wait_cnt <= LAT;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_last) begin
        r_rsp_result <= ck_result;
        r_rsp_id     <= r_id;
      end
      if (w_handshake) begin
        r_serve_cnt <= r_serve_cnt + CNT_W'(1);
        r_prio      <= ~r_rsp_id;
      end
    end
  end

endmodule
